// File: rtl/xoshiro128_stream_if.sv
// xoshiro128_stream_if: read/seed/jump bus between the PRNG and its consumer.
// Ports: rd_data/rd_valid/rd_ready (FIFO pop), seed_we/seed_addr/seed_data (state write),
//        level (FIFO occupancy), busy (jump running), jump_req (only with XOSHIRO_JUMP_EN).
`timescale 1ns/1ps
interface xoshiro128_stream_if #(
  parameter int DEPTH = 4
);
  localparam int LW = $clog2(DEPTH) + 1;

  logic [31:0]   rd_data;
  logic          rd_valid;
  logic          rd_ready;
  logic          seed_we;
  logic [1:0]    seed_addr;
  logic [31:0]   seed_data;
  logic [LW-1:0] level;
  logic          busy;
`ifdef XOSHIRO_JUMP_EN
  logic          jump_req;

  // master = consumer/CPU side, slave = generator
  modport master (
    input  rd_data, rd_valid, level, busy,
    output rd_ready, seed_we, seed_addr, seed_data, jump_req
  );
  modport slave (
    output rd_data, rd_valid, level, busy,
    input  rd_ready, seed_we, seed_addr, seed_data, jump_req
  );
`else
  modport master (
    input  rd_data, rd_valid, level, busy,
    output rd_ready, seed_we, seed_addr, seed_data
  );
  modport slave (
    output rd_data, rd_valid, level, busy,
    input  rd_ready, seed_we, seed_addr, seed_data
  );
`endif
endinterface

// File: rtl/xoshiro128_stream.sv
// xoshiro128_stream: xoshiro128 PRNG (scrambler MODE 0=++, 1=**, 2=+) feeding a DEPTH-entry prefetch FIFO.
// Ports: clk, rst_n (sync, active-low), bus (xoshiro128_stream_if.slave). A pushed word shows on rd_data
//        the next cycle; generator stalls while the FIFO is full. Optional jump engine under XOSHIRO_JUMP_EN.
`timescale 1ns/1ps
module xoshiro128_stream #(
  parameter int MODE  = 0,
  parameter int DEPTH = 4
) (
  input  logic               clk,
  input  logic               rst_n,
  xoshiro128_stream_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  typedef logic [3:0][31:0] state_t;  // element k holds s<k>

  localparam state_t RESET_STATE = {32'hD6CA8A07, 32'h473E5E7D, 32'h491DFB74, 32'h0D1929D2};

  function automatic logic [31:0] rotl(input logic [31:0] x, input int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic state_t step_f(input state_t s);
    state_t      n;
    logic [31:0] t;
    n    = s;
    t    = n[1] << 9;
    n[2] = n[2] ^ n[0];
    n[3] = n[3] ^ n[1];
    n[1] = n[1] ^ n[2];
    n[0] = n[0] ^ n[3];
    n[2] = n[2] ^ t;
    n[3] = rotl(n[3], 11);
    return n;
  endfunction

  // Output word is taken from the pre-step state.
  function automatic logic [31:0] scramble(input state_t s);
    logic [31:0] r;
    case (MODE)
      1:       r = rotl(s[1] * 32'd5, 7) * 32'd9;
      2:       r = s[0] + s[3];
      default: r = rotl(s[0] + s[3], 7) + s[0];
    endcase
    return r;
  endfunction

  state_t                 s_q;
  state_t                 s_nxt;
  logic [DEPTH-1:0][31:0] mem_q;
  logic [AW-1:0]          wr_ptr_q;
  logic [AW-1:0]          rd_ptr_q;
  logic [LW-1:0]          level_q;
  logic                   refill_en_q;  // holds refill off for the first cycle after reset

  logic busy_w;
  logic start_jump;
  logic seed_act;
  logic flush;
  logic full;
  logic rd_valid_w;
  logic push;
  logic pop;

`ifdef XOSHIRO_JUMP_EN
  // Jump polynomial, word 0 in the low bits so bit i is consumed at iteration i.
  localparam logic [127:0] JUMP_BITS = {32'h77F2DB5B, 32'h6FA035C3, 32'hF542D2D3, 32'h8764000B};

  logic       busy_q;
  state_t     acc_q;
  state_t     acc_x;
  logic [6:0] jcnt_q;
  logic       last_iter;

  assign busy_w     = busy_q;
  assign start_jump = bus.jump_req & ~busy_q;
  assign last_iter  = (jcnt_q == 7'd127);
  assign acc_x      = JUMP_BITS[jcnt_q] ? (acc_q ^ s_q) : acc_q;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      acc_q  <= '0;
      jcnt_q <= '0;
    end else if (start_jump) begin
      busy_q <= 1'b1;
      acc_q  <= '0;
      jcnt_q <= '0;
    end else if (busy_q) begin
      acc_q  <= acc_x;
      jcnt_q <= jcnt_q + 7'd1;
      if (last_iter) busy_q <= 1'b0;
    end
  end
`else
  assign busy_w     = 1'b0;
  assign start_jump = 1'b0;
`endif

  // A jump request wins over a seed write in the same cycle.
  assign seed_act   = bus.seed_we & ~busy_w & ~start_jump;
  assign flush      = seed_act | start_jump;
  assign full       = (level_q == LW'(DEPTH));
  assign rd_valid_w = (level_q != '0) & ~busy_w;
  assign pop        = rd_valid_w & bus.rd_ready;
  assign push       = refill_en_q & ~full & ~bus.seed_we & ~busy_w & ~start_jump;

  always_comb begin
    s_nxt = s_q;
    if (seed_act) begin
      s_nxt[bus.seed_addr] = bus.seed_data;
    end else if (push) begin
      s_nxt = step_f(s_q);
    end
`ifdef XOSHIRO_JUMP_EN
    // Final iteration loads the accumulator (including its own contribution).
    if (busy_q) s_nxt = last_iter ? acc_x : step_f(s_q);
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      s_q         <= RESET_STATE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      level_q     <= '0;
      refill_en_q <= 1'b0;
    end else begin
      s_q         <= s_nxt;
      refill_en_q <= 1'b1;
      if (flush) begin
        // push is already excluded on flush cycles; a same-cycle pop just drains the old word
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        level_q  <= '0;
      end else begin
        if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
        if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        level_q <= level_q + LW'(push) - LW'(pop);
      end
    end
  end

  // Storage needs no reset: rd_data is masked until an entry is valid.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= scramble(s_q);
  end

  assign bus.rd_valid = rd_valid_w;
  assign bus.rd_data  = rd_valid_w ? mem_q[rd_ptr_q] : 32'd0;
  assign bus.level    = level_q;
  assign bus.busy     = busy_w;

endmodule

// File: tb/tb_xoshiro128_stream.sv
// tb_xoshiro128_stream: randomized scoreboard bench for xoshiro128_stream.
// A C-style xoshiro128 model fills an expected-word queue whenever the stream is (re)seeded;
// a negedge monitor pops and compares every word the DUT hands out.
`timescale 1ns/1ps
module tb_xoshiro128_stream;
  localparam int MODE  = 0;
  localparam int DEPTH = 4;
  localparam int FILL  = 11000;

  typedef logic [31:0] w_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  xoshiro128_stream_if #(.DEPTH(DEPTH)) bus();

  xoshiro128_stream #(.MODE(MODE), .DEPTH(DEPTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  int checks  = 0;
  int errors  = 0;
  int pop_cnt = 0;
  w_t m_s[4];
  w_t exp_q[$];
  w_t kat_first[3];
  w_t kat_second[3];

  // ---------------- reference model ----------------
  function automatic w_t rotl(w_t x, int k);
    return (x << k) | (x >> (32 - k));
  endfunction

  function automatic w_t model_out();
    w_t r;
    case (MODE)
      1:       r = rotl(m_s[1] * 32'd5, 7) * 32'd9;
      2:       r = m_s[0] + m_s[3];
      default: r = rotl(m_s[0] + m_s[3], 7) + m_s[0];
    endcase
    return r;
  endfunction

  function automatic void model_step();
    w_t t;
    t      = m_s[1] << 9;
    m_s[2] ^= m_s[0];
    m_s[3] ^= m_s[1];
    m_s[1] ^= m_s[2];
    m_s[0] ^= m_s[3];
    m_s[2] ^= t;
    m_s[3] = rotl(m_s[3], 11);
  endfunction

  function automatic w_t model_next();
    w_t r;
    r = model_out();
    model_step();
    return r;
  endfunction

`ifdef XOSHIRO_JUMP_EN
  function automatic void model_jump();
    w_t jw[4];
    w_t acc[4];
    jw  = '{32'h8764000B, 32'hF542D2D3, 32'h6FA035C3, 32'h77F2DB5B};
    acc = '{32'd0, 32'd0, 32'd0, 32'd0};
    for (int i = 0; i < 4; i++) begin
      for (int b = 0; b < 32; b++) begin
        if (jw[i][b]) begin
          for (int k = 0; k < 4; k++) acc[k] ^= m_s[k];
        end
        model_step();
      end
    end
    for (int k = 0; k < 4; k++) m_s[k] = acc[k];
  endfunction
`endif

  function automatic void fill();
    exp_q.delete();
    for (int i = 0; i < FILL; i++) exp_q.push_back(model_next());
  endfunction

  // ---------------- checking ----------------
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual %08h required %08h", name, act, req);
    end
  endtask

  // Monitor: every completed pop must match the head of the expected stream.
  initial begin
    w_t e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.rd_valid && bus.rd_ready) begin
        pop_cnt++;
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty: actual word %08h required no pop", bus.rd_data);
        end else begin
          e = exp_q.pop_front();
          chk("pop_data", bus.rd_data, e);
        end
      end
    end
  end

  initial begin
    #1ms;
    errors++;
    $display("FAIL watchdog: actual time limit reached required run completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_level(input int target, input int max_cycles, input string name);
    int n;
    n = 0;
    while (int'(bus.level) != target && n < max_cycles) begin
      tick();
      n++;
    end
    chk(name, 32'(bus.level), 32'(target));
  endtask

  task automatic random_ready(input int cycles);
    repeat (cycles) begin
      bus.rd_ready = 1'($urandom_range(0, 1));
      tick();
    end
  endtask

  // Writes s0..s3 back to back; a pop in the first write cycle drains the old stream.
  task automatic seed_all(input w_t a0, input w_t a1, input w_t a2, input w_t a3);
    w_t v[4];
    v = '{a0, a1, a2, a3};
    bus.rd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      bus.seed_we   = 1'b1;
      bus.seed_addr = 2'(i);
      bus.seed_data = v[i];
      tick();
      chk("seed_flush_level", 32'(bus.level), 32'd0);
    end
    bus.seed_we = 1'b0;
    for (int k = 0; k < 4; k++) m_s[k] = v[k];
  endtask

  task automatic seed_and_check(input w_t a0, input w_t a1, input w_t a2, input w_t a3);
    seed_all(a0, a1, a2, a3);
    fill();
    chk("seed_valid_1cyc", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("seed_valid_2cyc", 32'(bus.rd_valid), 32'd1);
    chk("seed_first_word", bus.rd_data, exp_q[0]);
  endtask

  initial begin
    int p0;
    int n;
    kat_first  = '{32'h00000281, 32'h00002D00, 32'h00000005};
    kat_second = '{32'h00180387, 32'h00000000, 32'h00003007};
    bus.rd_ready  = 1'b0;
    bus.seed_we   = 1'b0;
    bus.seed_addr = 2'd0;
    bus.seed_data = 32'd0;
`ifdef XOSHIRO_JUMP_EN
    bus.jump_req  = 1'b0;
`endif

    // Reset state and default-seed stream
    repeat (3) tick();
    chk("rst_valid", 32'(bus.rd_valid), 32'd0);
    chk("rst_level", 32'(bus.level), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_data", bus.rd_data, 32'd0);
    m_s = '{32'h0D1929D2, 32'h491DFB74, 32'h473E5E7D, 32'hD6CA8A07};
    fill();
    rst_n = 1'b1;
    tick();
    chk("rst_valid_1cyc", 32'(bus.rd_valid), 32'd0);
    tick();
    chk("rst_valid_2cyc", 32'(bus.rd_valid), 32'd1);
    chk("rst_first_word", bus.rd_data, exp_q[0]);
    chk("rst_kat_word", bus.rd_data, 32'hFEF316C3);
    random_ready(40);

    // Seed {1,2,3,4}; stall to full, confirm the generator holds, then drain
    seed_and_check(32'd1, 32'd2, 32'd3, 32'd4);
    bus.rd_ready = 1'b0;
    wait_level(DEPTH, 50, "stall_full");
    chk("kat_first", bus.rd_data, kat_first[MODE]);
    repeat (20) tick();
    chk("stall_hold_level", 32'(bus.level), 32'(DEPTH));
    bus.rd_ready = 1'b1;
    tick();
    chk("kat_second", bus.rd_data, kat_second[MODE]);
    random_ready(30);

    // Random traffic with mid-stream reseeds
    for (int r = 0; r < 3; r++) begin
      random_ready(100);
      seed_and_check($urandom, $urandom, $urandom, $urandom);
    end
    random_ready(60);

    // All-zero seed gives zeros forever
    seed_and_check(32'd0, 32'd0, 32'd0, 32'd0);
    random_ready(40);

    // Continuous pop: one word per cycle at constant level
    seed_and_check($urandom, $urandom, $urandom, $urandom);
    bus.rd_ready = 1'b1;
    p0 = pop_cnt;
    repeat (10000) begin
      tick();
      chk("hold_level", 32'(bus.level), 32'd1);
    end
    chk("hold_rate", 32'(pop_cnt - p0), 32'd10000);
    random_ready(30);

`ifdef XOSHIRO_JUMP_EN
    // Jump from {1,2,3,4}; writes and jump requests while busy must be ignored
    seed_all(32'd1, 32'd2, 32'd3, 32'd4);
    bus.jump_req = 1'b1;
    model_jump();
    fill();
    tick();
    bus.jump_req = 1'b0;
    n = 0;
    while (bus.busy && n < 200) begin
      bus.seed_we   = (n == 10);
      bus.seed_addr = 2'd1;
      bus.seed_data = $urandom;
      bus.jump_req  = (n == 20);
      tick();
      n++;
      if (n == 64) chk("busy_rd_valid", 32'(bus.rd_valid), 32'd0);
    end
    bus.seed_we  = 1'b0;
    bus.jump_req = 1'b0;
    chk("busy_cycles", 32'(n), 32'd128);
    tick();
    chk("jump_valid", 32'(bus.rd_valid), 32'd1);
    chk("jump_first_word", bus.rd_data, exp_q[0]);
    random_ready(60);
`endif

    bus.rd_ready = 1'b0;
    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
